// File: rtl/register_file_dp_pkg.sv
// Shared constants for the system-controller register file: default geometry,
// export-register indices and the system-level reset image.
package reg_file_pkg;

    localparam int unsigned DEF_REG_WIDTH   = 8;
    localparam int unsigned DEF_ADDR_WIDTH  = 4;
    localparam int unsigned DEF_FILE_DEPTH  = 16;
    localparam int unsigned DEF_EXPORT_REGS = 4;

    localparam int unsigned REG_ALU_A    = 0;
    localparam int unsigned REG_ALU_B    = 1;
    localparam int unsigned REG_UART_CFG = 2;
    localparam int unsigned REG_DIV_CFG  = 3;

    // UART config 0x81 (reg 2) and divider config 0x20 (reg 3); all else zero.
    localparam logic [DEF_FILE_DEPTH*DEF_REG_WIDTH-1:0] SYS_INIT_VALUES =
        {96'h0, 8'h20, 8'h81, 8'h00, 8'h00};

    typedef enum logic [0:0] {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } rd_port_e;

endpackage

// File: rtl/register_file_dp_if.sv
// Command-side bus of the register file: one write port, two read ports,
// error pulses and the exported low registers.
interface register_file_dp_if
    import reg_file_pkg::*;
#(
    parameter int unsigned REG_WIDTH   = DEF_REG_WIDTH,
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned EXPORT_REGS = DEF_EXPORT_REGS
);

    logic                              i_WrEn;
    logic [ADDR_WIDTH-1:0]             i_WrAddr;
    logic [REG_WIDTH-1:0]              i_WrData;
    logic                              i_RdEn_A;
    logic [ADDR_WIDTH-1:0]             i_RdAddr_A;
    logic [REG_WIDTH-1:0]              o_RdData_A;
    logic                              o_RdData_Valid_A;
    logic                              i_RdEn_B;
    logic [ADDR_WIDTH-1:0]             i_RdAddr_B;
    logic [REG_WIDTH-1:0]              o_RdData_B;
    logic                              o_RdData_Valid_B;
    logic                              o_WrErr;
    logic [1:0]                        o_RdErr;
    logic [EXPORT_REGS*REG_WIDTH-1:0]  o_REGS;

    modport master (
        output i_WrEn, i_WrAddr, i_WrData,
        output i_RdEn_A, i_RdAddr_A, i_RdEn_B, i_RdAddr_B,
        input  o_RdData_A, o_RdData_Valid_A, o_RdData_B, o_RdData_Valid_B,
        input  o_WrErr, o_RdErr, o_REGS
    );

    modport slave (
        input  i_WrEn, i_WrAddr, i_WrData,
        input  i_RdEn_A, i_RdAddr_A, i_RdEn_B, i_RdAddr_B,
        output o_RdData_A, o_RdData_Valid_A, o_RdData_B, o_RdData_Valid_B,
        output o_WrErr, o_RdErr, o_REGS
    );

endinterface

// File: rtl/register_file_dp_rd_port.sv
// One registered read port: address decode over the flat register bus,
// optional same-cycle write forwarding, and data/valid/error flops.
module register_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int unsigned REG_WIDTH  = DEF_REG_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned FILE_DEPTH = DEF_FILE_DEPTH,
    parameter bit          RD_BYPASS  = 1'b0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rd_en,
    input  logic [ADDR_WIDTH-1:0]          rd_addr,
    input  logic [FILE_DEPTH*REG_WIDTH-1:0] regs,
    input  logic                           byp_en,
    input  logic [ADDR_WIDTH-1:0]          byp_addr,
    input  logic [REG_WIDTH-1:0]           byp_data,
    output logic [REG_WIDTH-1:0]           rd_data,
    output logic                           rd_valid,
    output logic                           rd_err
);

    logic                 in_range;
    logic [REG_WIDTH-1:0] sel;

    // An unmatched (out-of-range) address leaves sel at zero; byp_en only
    // ever flags accepted, hence in-range, writes.
    always_comb begin
        in_range = ({1'b0, rd_addr} < (ADDR_WIDTH+1)'(FILE_DEPTH));
        sel      = '0;
        for (int unsigned i = 0; i < FILE_DEPTH; i++) begin
            if (rd_addr == ADDR_WIDTH'(i)) begin
                sel = regs[i*REG_WIDTH +: REG_WIDTH];
            end
        end
        if (RD_BYPASS && byp_en && (byp_addr == rd_addr)) begin
            sel = byp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            rd_err   <= rd_en && !in_range;
            if (rd_en) begin
                rd_data <= sel;
            end
        end
    end

endmodule

// File: rtl/register_file_dp.sv
// Dual-read, single-write register file with per-register write protection,
// per-register reset values and a flat export of the low registers.
module register_file_dp
    import reg_file_pkg::*;
#(
    parameter int unsigned REG_WIDTH   = DEF_REG_WIDTH,
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned FILE_DEPTH  = DEF_FILE_DEPTH,
    parameter int unsigned EXPORT_REGS = DEF_EXPORT_REGS,
    parameter logic [FILE_DEPTH-1:0]           RO_MASK     = '0,
    parameter logic [FILE_DEPTH*REG_WIDTH-1:0] INIT_VALUES = '0,
    parameter bit          RD_BYPASS   = 1'b0
) (
    input logic               i_CLK,
    input logic               i_RST,
    register_file_dp_if.slave bus
);

    if (FILE_DEPTH < 2 || FILE_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
        $fatal(1, "register_file_dp: FILE_DEPTH out of range 2..2**ADDR_WIDTH");
    end
    if (EXPORT_REGS < 1 || EXPORT_REGS > FILE_DEPTH) begin : g_bad_export
        $fatal(1, "register_file_dp: EXPORT_REGS out of range 1..FILE_DEPTH");
    end

    logic [FILE_DEPTH*REG_WIDTH-1:0] regs_q;
    logic [FILE_DEPTH-1:0]           wr_hit;
    logic                            wr_accept;
    logic                            wr_reject;
    logic                            wr_err_q;

    // Decoding per register folds the range check and the read-only mask
    // into one hit vector; no hit means the write is rejected.
    always_comb begin
        wr_hit = '0;
        for (int unsigned i = 0; i < FILE_DEPTH; i++) begin
            wr_hit[i] = bus.i_WrEn && (bus.i_WrAddr == ADDR_WIDTH'(i)) && !RO_MASK[i];
        end
        wr_accept = |wr_hit;
        wr_reject = bus.i_WrEn && !wr_accept;
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            regs_q   <= INIT_VALUES;
            wr_err_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < FILE_DEPTH; i++) begin
                if (wr_hit[i]) begin
                    regs_q[i*REG_WIDTH +: REG_WIDTH] <= bus.i_WrData;
                end
            end
            wr_err_q <= wr_reject;
        end
    end

    assign bus.o_WrErr = wr_err_q;
    assign bus.o_REGS  = regs_q[EXPORT_REGS*REG_WIDTH-1:0];

    register_file_rd_port #(
        .REG_WIDTH  (REG_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .FILE_DEPTH (FILE_DEPTH),
        .RD_BYPASS  (RD_BYPASS)
    ) u_rd_a (
        .clk      (i_CLK),
        .rst      (i_RST),
        .rd_en    (bus.i_RdEn_A),
        .rd_addr  (bus.i_RdAddr_A),
        .regs     (regs_q),
        .byp_en   (wr_accept),
        .byp_addr (bus.i_WrAddr),
        .byp_data (bus.i_WrData),
        .rd_data  (bus.o_RdData_A),
        .rd_valid (bus.o_RdData_Valid_A),
        .rd_err   (bus.o_RdErr[PORT_A])
    );

    register_file_rd_port #(
        .REG_WIDTH  (REG_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .FILE_DEPTH (FILE_DEPTH),
        .RD_BYPASS  (RD_BYPASS)
    ) u_rd_b (
        .clk      (i_CLK),
        .rst      (i_RST),
        .rd_en    (bus.i_RdEn_B),
        .rd_addr  (bus.i_RdAddr_B),
        .regs     (regs_q),
        .byp_en   (wr_accept),
        .byp_addr (bus.i_WrAddr),
        .byp_data (bus.i_WrData),
        .rd_data  (bus.o_RdData_B),
        .rd_valid (bus.o_RdData_Valid_B),
        .rd_err   (bus.o_RdErr[PORT_B])
    );

endmodule

// File: tb/tb_register_file_dp.sv
// Scoreboard bench: two register files (bypass off / on) share one stimulus
// stream and are checked cycle by cycle against an array-based model.
module tb_register_file_dp;
    import reg_file_pkg::*;

    localparam int unsigned W     = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 12;
    localparam int unsigned EXP   = 4;
    localparam logic [DEPTH-1:0]   RO   = 12'h008;
    localparam logic [DEPTH*W-1:0] INIT = {8'h00, 8'h5A, 8'h00, 8'h00, 8'h64, 8'h00,
                                           8'h00, 8'h00, 8'h20, 8'h81, 8'h00, 8'h00};

    logic clk = 1'b0;
    logic rst;
    logic wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic rd_en_a, rd_en_b;
    logic [AW-1:0] rd_addr_a, rd_addr_b;

    always #5 clk = ~clk;

    register_file_dp_if #(.REG_WIDTH(W), .ADDR_WIDTH(AW), .EXPORT_REGS(EXP)) if_nb ();
    register_file_dp_if #(.REG_WIDTH(W), .ADDR_WIDTH(AW), .EXPORT_REGS(EXP)) if_b ();

    assign if_nb.i_WrEn = wr_en;      assign if_b.i_WrEn = wr_en;
    assign if_nb.i_WrAddr = wr_addr;  assign if_b.i_WrAddr = wr_addr;
    assign if_nb.i_WrData = wr_data;  assign if_b.i_WrData = wr_data;
    assign if_nb.i_RdEn_A = rd_en_a;  assign if_b.i_RdEn_A = rd_en_a;
    assign if_nb.i_RdAddr_A = rd_addr_a; assign if_b.i_RdAddr_A = rd_addr_a;
    assign if_nb.i_RdEn_B = rd_en_b;  assign if_b.i_RdEn_B = rd_en_b;
    assign if_nb.i_RdAddr_B = rd_addr_b; assign if_b.i_RdAddr_B = rd_addr_b;

    register_file_dp #(
        .REG_WIDTH(W), .ADDR_WIDTH(AW), .FILE_DEPTH(DEPTH), .EXPORT_REGS(EXP),
        .RO_MASK(RO), .INIT_VALUES(INIT), .RD_BYPASS(1'b0)
    ) dut_nb (.i_CLK(clk), .i_RST(rst), .bus(if_nb));

    register_file_dp #(
        .REG_WIDTH(W), .ADDR_WIDTH(AW), .FILE_DEPTH(DEPTH), .EXPORT_REGS(EXP),
        .RO_MASK(RO), .INIT_VALUES(INIT), .RD_BYPASS(1'b1)
    ) dut_b (.i_CLK(clk), .i_RST(rst), .bus(if_b));

    typedef struct packed {
        logic [W-1:0]     data_a;
        logic [W-1:0]     data_b;
        logic             valid_a;
        logic             valid_b;
        logic [1:0]       rd_err;
        logic             wr_err;
        logic [EXP*W-1:0] regs;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];

    // Model state: register contents (reset image listed by index) and the
    // last returned read data per DUT per port.
    logic [W-1:0] init_tab [16] = '{8'h00, 8'h00, 8'h81, 8'h20, 8'h00, 8'h00, 8'h00, 8'h64,
                                    8'h00, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [W-1:0] mem  [16];
    logic [W-1:0] hold [2][2];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [W-1:0] model_read(input bit byp, input bit acc, input logic [AW-1:0] a);
        if (int'(a) >= DEPTH) return '0;
        if (byp && acc && a == wr_addr) return wr_data;
        return mem[a];
    endfunction

    task automatic predict();
        exp_t e;
        bit acc;
        acc = wr_en && int'(wr_addr) < DEPTH && wr_addr != 4'd3;
        for (int d = 0; d < 2; d++) begin
            e = '0;
            if (rst) begin
                hold[d][0] = '0;
                hold[d][1] = '0;
            end else begin
                if (rd_en_a) begin
                    hold[d][0] = model_read(d == 1, acc, rd_addr_a);
                    e.valid_a = 1'b1;
                    e.rd_err[0] = int'(rd_addr_a) >= DEPTH;
                end
                if (rd_en_b) begin
                    hold[d][1] = model_read(d == 1, acc, rd_addr_b);
                    e.valid_b = 1'b1;
                    e.rd_err[1] = int'(rd_addr_b) >= DEPTH;
                end
                e.wr_err = wr_en && !acc;
            end
            e.data_a = hold[d][0];
            e.data_b = hold[d][1];
            if (d == 0) exp_q0.push_back(e);
            else        exp_q1.push_back(e);
        end
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] = init_tab[i];
        end else if (acc) begin
            mem[wr_addr] = wr_data;
        end
        // regs reflect post-edge contents, identical for both builds.
        exp_q0[$].regs = {mem[3], mem[2], mem[1], mem[0]};
        exp_q1[$].regs = {mem[3], mem[2], mem[1], mem[0]};
    endtask

    task automatic cyc(input bit r, input bit we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                       input bit ea, input logic [AW-1:0] aa, input bit eb, input logic [AW-1:0] ab);
        rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
        rd_en_a = ea; rd_addr_a = aa; rd_en_b = eb; rd_addr_b = ab;
        predict();
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q0.size() > 0) begin
                e = exp_q0.pop_front();
                check("nb.data_a",  32'(if_nb.o_RdData_A),       32'(e.data_a));
                check("nb.valid_a", 32'(if_nb.o_RdData_Valid_A), 32'(e.valid_a));
                check("nb.data_b",  32'(if_nb.o_RdData_B),       32'(e.data_b));
                check("nb.valid_b", 32'(if_nb.o_RdData_Valid_B), 32'(e.valid_b));
                check("nb.rd_err",  32'(if_nb.o_RdErr),          32'(e.rd_err));
                check("nb.wr_err",  32'(if_nb.o_WrErr),          32'(e.wr_err));
                check("nb.regs",    32'(if_nb.o_REGS),           32'(e.regs));
            end
            if (exp_q1.size() > 0) begin
                e = exp_q1.pop_front();
                check("b.data_a",  32'(if_b.o_RdData_A),       32'(e.data_a));
                check("b.valid_a", 32'(if_b.o_RdData_Valid_A), 32'(e.valid_a));
                check("b.data_b",  32'(if_b.o_RdData_B),       32'(e.data_b));
                check("b.valid_b", 32'(if_b.o_RdData_Valid_B), 32'(e.valid_b));
                check("b.rd_err",  32'(if_b.o_RdErr),          32'(e.rd_err));
                check("b.wr_err",  32'(if_b.o_WrErr),          32'(e.wr_err));
                check("b.regs",    32'(if_b.o_REGS),           32'(e.regs));
            end
        end
    end

    initial begin
        bit r, we, ea, eb;
        logic [AW-1:0] wa, aa, ab;
        logic [W-1:0]  wd;

        for (int i = 0; i < 16; i++) mem[i] = '0;
        hold[0][0] = '0; hold[0][1] = '0; hold[1][0] = '0; hold[1][1] = '0;

        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 8'hEE, 1, 2, 1, 3);     // requests alongside reset are dropped
        idle();
        cyc(0, 0, 0, 0, 1, 2, 0, 0);         // read A 2 -> 0x81
        idle();
        cyc(0, 1, 1, 8'h0F, 0, 0, 0, 0);
        cyc(0, 1, 1, 8'h05, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 1);         // read B 1 -> 0x05
        idle();
        cyc(0, 1, 3, 8'hAA, 0, 0, 0, 0);     // read-only target rejected
        cyc(0, 0, 0, 0, 1, 3, 0, 0);
        idle();
        cyc(0, 1, 14, 8'h11, 1, 13, 0, 0);   // out-of-range read and write together
        idle();
        cyc(0, 1, 7, 8'hC8, 1, 7, 0, 0);     // bypass differs between builds
        cyc(0, 0, 0, 0, 1, 7, 0, 0);
        idle();
        cyc(0, 0, 0, 0, 1, 7, 1, 10);
        cyc(0, 0, 0, 0, 1, 7, 1, 10);
        cyc(1, 0, 0, 0, 1, 7, 1, 10);
        cyc(0, 0, 0, 0, 1, 7, 1, 10);
        idle();
        cyc(0, 1, 5, 8'h3C, 1, 5, 1, 5);     // both ports, same address, with write
        cyc(0, 1, 11, 8'hB7, 1, 5, 1, 5);
        cyc(0, 0, 0, 0, 1, 11, 1, 12);
        idle();

        for (int n = 0; n < 600; n++) begin
            r  = ($urandom_range(0, 49) == 0);
            we = $urandom_range(0, 1) == 1;
            wa = AW'($urandom_range(0, 15));
            wd = W'($urandom);
            ea = $urandom_range(0, 2) != 0;
            aa = AW'($urandom_range(0, 15));
            eb = $urandom_range(0, 2) != 0;
            ab = AW'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) aa = wa;
            if ($urandom_range(0, 3) == 0) ab = wa;
            cyc(r, we, wa, wd, ea, aa, eb, ab);
        end
        idle();
        idle();

        for (int i = 0; i < 10 && (exp_q0.size() > 0 || exp_q1.size() > 0); i++) begin
            @(posedge clk);
            #2;
        end
        n_checks++;
        if (exp_q0.size() > 0 || exp_q1.size() > 0) begin
            n_fail++;
            $display("FAIL drain: got %0d/%0d pending expected 0", exp_q0.size(), exp_q1.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
